// File: rtl/lebug_pkg.sv
// Shared definitions for the chain accumulator slice: op codes, vector type, config counter width.
package lebug_pkg;

  localparam int VEC_N     = 8;
  localparam int LANE_W    = 32;
  localparam int CFG_CNT_W = 8;

  localparam logic [7:0] ACC_OP_PASS = 8'd0;
  localparam logic [7:0] ACC_OP_SUM  = 8'd1;
  localparam logic [7:0] ACC_OP_MAX  = 8'd2;

  typedef logic [VEC_N-1:0][LANE_W-1:0] vector_t;

  typedef enum logic {
    CHAIN_IDLE  = 1'b0,
    CHAIN_ACCUM = 1'b1
  } chain_state_e;

  // Only sum and max accumulate; every other op value is treated as pass-through.
  function automatic logic is_acc_op(input logic [7:0] op);
    return (op == ACC_OP_SUM) || (op == ACC_OP_MAX);
  endfunction

endpackage

// File: rtl/acc_lane_alu.sv
// One lane of the accumulator datapath: combines base with the incoming lane value.
module acc_lane_alu
  import lebug_pkg::*;
#(
  parameter int DATA_WIDTH = LANE_W
) (
  input  logic [7:0]            op,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [DATA_WIDTH-1:0] in_lane,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  sat
);

  logic [DATA_WIDTH:0] sum;

  // The extra sum bit is the carry out; when it is set the lane clamps to all ones.
  always_comb begin
    sum    = {1'b0, base} + {1'b0, in_lane};
    result = in_lane;
    sat    = 1'b0;
    case (op)
      ACC_OP_PASS: result = in_lane;
      ACC_OP_SUM: begin
        if (sum[DATA_WIDTH]) begin
          result = '1;
          sat    = 1'b1;
        end else begin
          result = sum[DATA_WIDTH-1:0];
        end
      end
      ACC_OP_MAX: result = (base > in_lane) ? base : in_lane;
      default: result = in_lane;
    endcase
  end

endmodule

// File: rtl/chain_accumulator.sv
// Per-chain frame accumulator: sums or maxes the vectors of a frame, or passes them through.
module chain_accumulator
  import lebug_pkg::*;
#(
  parameter int                      N                       = VEC_N,
  parameter int                      DATA_WIDTH              = LANE_W,
  parameter int                      MAX_CHAINS              = 4,
  parameter logic [7:0]              PERSONAL_CONFIG_ID      = 8'd2,
  parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE_ACC_OP = '0,
  localparam int                     CW                      = $clog2(MAX_CHAINS)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             tracing,
  input  logic                             valid_in,
  input  logic                             eof_in,
  input  logic                             bof_in,
  input  logic [CW-1:0]                    chainId_in,
  input  logic [7:0]                       configId,
  input  logic [7:0]                       configData,
  input  logic [N-1:0][DATA_WIDTH-1:0]     vector_in,
  output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
  output logic [CW-1:0]                    chainId_out,
  output logic                             valid_out,
  output logic                             eof_out,
  output logic                             bof_out,
  output logic                             overflow_out
);

  localparam logic [CFG_CNT_W-1:0] CFG_SLOTS = CFG_CNT_W'(MAX_CHAINS);

  logic [N-1:0][DATA_WIDTH-1:0] acc [MAX_CHAINS];
  chain_state_e                 in_frame [MAX_CHAINS];
  logic [MAX_CHAINS-1:0]        ovf;
  logic [7:0]                   fw_op [MAX_CHAINS];
  logic [CFG_CNT_W-1:0]         byte_counter;

  logic [7:0]                   cur_op;
  logic                         start;
  logic [N-1:0][DATA_WIDTH-1:0] base;
  logic [N-1:0][DATA_WIDTH-1:0] new_vec;
  logic [N-1:0]                 lane_sat;
  logic                         ovf_next;

  // A frame restarts on bof or whenever the chain is idle, so a stray mid-frame vector begins from zero.
  always_comb begin
    cur_op   = fw_op[chainId_in];
    start    = bof_in || (in_frame[chainId_in] == CHAIN_IDLE);
    base     = start ? '0 : acc[chainId_in];
    ovf_next = (!start && ovf[chainId_in]) || (|lane_sat);
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    acc_lane_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .op      (cur_op),
      .base    (base[g]),
      .in_lane (vector_in[g]),
      .result  (new_vec[g]),
      .sat     (lane_sat[g])
    );
  end

  // Outputs other than valid_out hold whenever nothing is emitted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vector_out   <= '0;
      chainId_out  <= '0;
      valid_out    <= 1'b0;
      eof_out      <= 1'b0;
      bof_out      <= 1'b0;
      overflow_out <= 1'b0;
      ovf          <= '0;
      byte_counter <= '0;
      for (int c = 0; c < MAX_CHAINS; c++) begin
        acc[c]      <= '0;
        in_frame[c] <= CHAIN_IDLE;
        fw_op[c]    <= INITIAL_FIRMWARE_ACC_OP[c*8 +: 8];
      end
    end else begin
      valid_out <= 1'b0;
      if (tracing) begin
        if (valid_in) begin
          if (is_acc_op(cur_op)) begin
            if (eof_in) begin
              vector_out           <= new_vec;
              valid_out            <= 1'b1;
              eof_out              <= 1'b1;
              bof_out              <= 1'b1;
              chainId_out          <= chainId_in;
              overflow_out         <= ovf_next;
              in_frame[chainId_in] <= CHAIN_IDLE;
              ovf[chainId_in]      <= 1'b0;
            end else begin
              acc[chainId_in]      <= new_vec;
              in_frame[chainId_in] <= CHAIN_ACCUM;
              ovf[chainId_in]      <= ovf_next;
            end
          end else begin
            vector_out   <= vector_in;
            valid_out    <= 1'b1;
            eof_out      <= eof_in;
            bof_out      <= bof_in;
            chainId_out  <= chainId_in;
            overflow_out <= 1'b0;
          end
        end
      end else if (configId == PERSONAL_CONFIG_ID) begin
        if (byte_counter < CFG_SLOTS) begin
          fw_op[byte_counter[CW-1:0]] <= configData;
        end
        if (byte_counter != '1) begin
          byte_counter <= byte_counter + 1'b1;
        end
      end else begin
        byte_counter <= '0;
      end
    end
  end

endmodule

// File: tb/tb_chain_accumulator.sv
// Self-checking bench for chain_accumulator: directed frames plus random traffic against a frame-level model.
module tb_chain_accumulator;
  import lebug_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        tracing;
  logic        valid_in;
  logic        eof_in;
  logic        bof_in;
  logic [1:0]  chain_id_in;
  logic [7:0]  config_id;
  logic [7:0]  config_data;
  vector_t     vec_in;
  vector_t     vec_out;
  logic [1:0]  chain_id_out;
  logic        valid_out;
  logic        eof_out;
  logic        bof_out;
  logic        overflow_out;

  int check_count = 0;
  int error_count = 0;

  // Reference state: accumulated frame per chain, plus the outputs the DUT should currently show.
  logic [31:0] m_acc [4][8];
  bit          m_in_frame [4];
  bit          m_ovf [4];
  logic [7:0]  m_op [4];
  int          m_byte_cnt;
  vector_t     e_vec;
  bit          e_valid, e_eof, e_bof, e_ovf;
  logic [1:0]  e_chain;

  chain_accumulator dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tracing      (tracing),
    .valid_in     (valid_in),
    .eof_in       (eof_in),
    .bof_in       (bof_in),
    .chainId_in   (chain_id_in),
    .configId     (config_id),
    .configData   (config_data),
    .vector_in    (vec_in),
    .vector_out   (vec_out),
    .chainId_out  (chain_id_out),
    .valid_out    (valid_out),
    .eof_out      (eof_out),
    .bof_out      (bof_out),
    .overflow_out (overflow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int c = 0; c < 4; c++) begin
      for (int l = 0; l < 8; l++) m_acc[c][l] = '0;
      m_in_frame[c] = 1'b0;
      m_ovf[c]      = 1'b0;
      m_op[c]       = 8'd0;
    end
    m_byte_cnt = 0;
    e_vec = '0; e_valid = 0; e_eof = 0; e_bof = 0; e_ovf = 0; e_chain = '0;
  endfunction

  // One cycle of behaviour straight from the frame rules, using 64-bit arithmetic for the sums.
  function automatic void modelStep(input bit tr, input bit va, input bit bo, input bit eo,
                                    input logic [1:0] ch, input logic [7:0] cid,
                                    input logic [7:0] cdat, input vector_t vec);
    logic [7:0]  op;
    bit          start, sat;
    longint      s, b;
    logic [31:0] nw [8];
    e_valid = 0;
    if (!tr) begin
      if (cid == 8'd2) begin
        if (m_byte_cnt < 4) m_op[m_byte_cnt] = cdat;
        if (m_byte_cnt < 255) m_byte_cnt++;
      end else begin
        m_byte_cnt = 0;
      end
    end else if (va) begin
      op = m_op[ch];
      if (op == 8'd1 || op == 8'd2) begin
        start = bo || !m_in_frame[ch];
        sat   = 0;
        for (int l = 0; l < 8; l++) begin
          b = start ? 0 : longint'(m_acc[ch][l]);
          if (op == 8'd1) begin
            s = b + longint'(vec[l]);
            if (s > 64'hFFFF_FFFF) begin
              nw[l] = 32'hFFFF_FFFF;
              sat   = 1;
            end else begin
              nw[l] = s[31:0];
            end
          end else begin
            nw[l] = (longint'(vec[l]) > b) ? vec[l] : b[31:0];
          end
        end
        if (eo) begin
          for (int l = 0; l < 8; l++) e_vec[l] = nw[l];
          e_valid = 1; e_eof = 1; e_bof = 1; e_chain = ch;
          e_ovf = (!start && m_ovf[ch]) || sat;
          m_in_frame[ch] = 0;
          m_ovf[ch]      = 0;
        end else begin
          for (int l = 0; l < 8; l++) m_acc[ch][l] = nw[l];
          m_ovf[ch]      = (!start && m_ovf[ch]) || sat;
          m_in_frame[ch] = 1;
        end
      end else begin
        e_vec = vec; e_valid = 1; e_eof = eo; e_bof = bo; e_chain = ch; e_ovf = 0;
      end
    end
  endfunction

  task automatic compareAll();
    checkOutput("valid_out", valid_out, e_valid);
    checkOutput("vector_out", vec_out, e_vec);
    checkOutput("eof_out", eof_out, e_eof);
    checkOutput("bof_out", bof_out, e_bof);
    checkOutput("chainId_out", chain_id_out, e_chain);
    checkOutput("overflow_out", overflow_out, e_ovf);
  endtask

  // Called at a falling edge: drive, step the model, let the DUT clock, compare on the next falling edge.
  task automatic applyStimulus(input bit tr, input bit va, input bit bo, input bit eo,
                               input logic [1:0] ch, input logic [7:0] cid,
                               input logic [7:0] cdat, input vector_t vec);
    tracing = tr; valid_in = va; bof_in = bo; eof_in = eo;
    chain_id_in = ch; config_id = cid; config_data = cdat; vec_in = vec;
    modelStep(tr, va, bo, eo, ch, cid, cdat, vec);
    @(posedge clk);
    @(negedge clk);
    compareAll();
  endtask

  function automatic vector_t rampVec(input int first);
    vector_t v;
    for (int l = 0; l < 8; l++) v[l] = 32'(first + l);
    return v;
  endfunction

  function automatic vector_t randVec();
    vector_t v;
    for (int l = 0; l < 8; l++)
      v[l] = ($urandom_range(0, 3) == 0) ? (32'hFFFF_0000 | $urandom) : 32'($urandom_range(0, 1000));
    return v;
  endfunction

  task automatic configureOps(input logic [7:0] o0, input logic [7:0] o1,
                              input logic [7:0] o2, input logic [7:0] o3);
    logic [7:0] ops [4];
    ops = '{o0, o1, o2, o3};
    applyStimulus(0, 1, 1, 1, 2'd0, 8'd7, 8'd0, rampVec(50));
    for (int k = 0; k < 4; k++)
      applyStimulus(0, 1, 1, 1, 2'(k), 8'd2, ops[k], rampVec(60));
    applyStimulus(0, 0, 0, 0, 2'd0, 8'd0, 8'd0, '0);
  endtask

  initial begin
    vector_t v;
    reset_n = 1'b0; tracing = 0; valid_in = 0; eof_in = 0; bof_in = 0;
    chain_id_in = '0; config_id = '0; config_data = '0; vec_in = '0;
    modelReset();
    repeat (2) @(negedge clk);
    compareAll();
    reset_n = 1'b1;

    $display("[TB] sum frame on chain 0");
    configureOps(8'd1, 8'd1, 8'd1, 8'd1);
    applyStimulus(1, 1, 1, 0, 2'd0, 8'd0, 8'd0, rampVec(1));
    checkOutput("t1_quiet_bof", valid_out, 1'b0);
    applyStimulus(1, 1, 0, 0, 2'd0, 8'd0, 8'd0, rampVec(1));
    checkOutput("t1_quiet_mid", valid_out, 1'b0);
    applyStimulus(1, 1, 0, 1, 2'd0, 8'd0, 8'd0, rampVec(2));
    checkOutput("t1_lane0", vec_out[0], 32'd4);
    checkOutput("t1_lane7", vec_out[7], 32'd25);
    checkOutput("t1_eof", eof_out, 1'b1);

    $display("[TB] interleaved max on chain 1 and sum on chain 0");
    configureOps(8'd1, 8'd2, 8'd1, 8'd1);
    v = '0; v[0] = 32'd5;
    applyStimulus(1, 1, 1, 0, 2'd1, 8'd0, 8'd0, v);
    applyStimulus(1, 1, 1, 0, 2'd0, 8'd0, 8'd0, rampVec(1));
    v[0] = 32'd9;
    applyStimulus(1, 1, 0, 0, 2'd1, 8'd0, 8'd0, v);
    applyStimulus(1, 1, 0, 0, 2'd0, 8'd0, 8'd0, rampVec(1));
    v[0] = 32'd3;
    applyStimulus(1, 1, 0, 1, 2'd1, 8'd0, 8'd0, v);
    checkOutput("t2_max_lane0", vec_out[0], 32'd9);
    checkOutput("t2_max_chain", chain_id_out, 2'd1);
    applyStimulus(1, 1, 0, 1, 2'd0, 8'd0, 8'd0, rampVec(2));
    checkOutput("t2_sum_lane0", vec_out[0], 32'd4);

    $display("[TB] saturation");
    v = '0; v[0] = 32'hFFFF_FFF0;
    applyStimulus(1, 1, 1, 0, 2'd0, 8'd0, 8'd0, v);
    v[0] = 32'h20;
    applyStimulus(1, 1, 0, 1, 2'd0, 8'd0, 8'd0, v);
    checkOutput("t3_sat_lane0", vec_out[0], 32'hFFFF_FFFF);
    checkOutput("t3_ovf_set", overflow_out, 1'b1);
    v[0] = 32'd1;
    applyStimulus(1, 1, 1, 1, 2'd0, 8'd0, 8'd0, v);
    checkOutput("t3_ovf_clear", overflow_out, 1'b0);

    $display("[TB] config bytes 0,2,1,0");
    configureOps(8'd0, 8'd2, 8'd1, 8'd0);
    applyStimulus(1, 1, 0, 0, 2'd0, 8'd0, 8'd0, rampVec(7));
    checkOutput("t4_echo_valid", valid_out, 1'b1);
    checkOutput("t4_echo_lane0", vec_out[0], 32'd7);

    $display("[TB] single-vector frame and idle restart");
    applyStimulus(1, 1, 1, 1, 2'd2, 8'd0, 8'd0, rampVec(40));
    checkOutput("t5_single_lane3", vec_out[3], 32'd43);
    applyStimulus(1, 1, 0, 0, 2'd2, 8'd0, 8'd0, rampVec(10));
    applyStimulus(1, 1, 0, 1, 2'd2, 8'd0, 8'd0, rampVec(1));
    checkOutput("t5_restart_lane0", vec_out[0], 32'd11);

    $display("[TB] reset mid-frame");
    applyStimulus(1, 1, 1, 0, 2'd2, 8'd0, 8'd0, rampVec(3));
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_vec", vec_out, 256'd0);
    checkOutput("t6_rst_eof", eof_out, 1'b0);
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1, 1, 0, 1, 2'd2, 8'd0, 8'd0, rampVec(1));
    checkOutput("t6_pass_lane7", vec_out[7], 32'd8);
    configureOps(8'd1, 8'd1, 8'd1, 8'd1);
    applyStimulus(1, 1, 0, 1, 2'd2, 8'd0, 8'd0, rampVec(1));
    checkOutput("t6_sum_lane7", vec_out[7], 32'd8);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0)
        applyStimulus(0, $urandom_range(0, 1), 1'b0, 1'b0, 2'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) == 0) ? 8'd5 : 8'd2, 8'($urandom_range(0, 3)), randVec());
      else
        applyStimulus(1, $urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3,
                      2'($urandom_range(0, 3)), 8'd0, 8'd0, randVec());
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/chain_accumulator.md
Name: chain_accumulator

Overview:
- Sits directly downstream of the filter/reduce stage and consumes its per-vector histogram or pass-through vectors.
- Keeps one accumulator vector per chainId and combines the vectors of one frame (bof_in..eof_in) with a per-chain firmware operation.
- Emits one result vector per frame at eof, or passes every vector through unchanged, toward the packing/trace-buffer stage.
- Reconfigured over the same configId/configData byte bus as its neighbours while tracing is low.

Parameters:
N, 8, vector lanes
DATA_WIDTH, 32, lane width (unsigned)
MAX_CHAINS, 4, number of independent chains
PERSONAL_CONFIG_ID, 2, configId value addressing this block
INITIAL_FIRMWARE_ACC_OP, '{MAX_CHAINS{0}}, per-chain op byte after reset: 0=pass, 1=sum, 2=max

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
tracing  input  1  1=process vectors, 0=configuration mode
valid_in  input  1  vector_in qualifier
eof_in  input  1  last vector of frame
bof_in  input  1  first vector of frame
chainId_in  input  $clog2(MAX_CHAINS)  chain of vector_in
configId  input  8  config target id
configData  input  8  config byte
vector_in  input  N x DATA_WIDTH  input vector
vector_out  output  N x DATA_WIDTH  result vector
chainId_out  output  $clog2(MAX_CHAINS)  chain of vector_out
valid_out  output  1  vector_out qualifier
eof_out  output  1  eof marker for vector_out
bof_out  output  1  bof marker for vector_out
overflow_out  output  1  a sum lane saturated within the emitted frame

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0.
  - Accumulators, in_frame, ovf bits and byte_counter cleared.
  - firmware_op reloaded from INITIAL_FIRMWARE_ACC_OP.
  - Reset mid-frame discards the partial frame; no output is produced for it.
- Per-chain state: acc[c] (N x DATA_WIDTH), in_frame[c] (IDLE=0 / ACCUM=1), ovf[c]. Chains are fully independent; interleaving chains is legal.
- Latency 1 cycle, registered outputs, no backpressure. Input is accepted every cycle.
- tracing=1, valid_in=1, c=chainId_in, op=firmware_op[c]:
  - op=0: vector_out=vector_in, valid/bof/eof/chainId copied, overflow_out=0; acc[c] and in_frame[c] untouched.
  - op=1 or op=2: start=bof_in | !in_frame[c]. Base = start ? 0 : acc[c].
  - op=1: new = base + vector_in lane-wise, saturating at 2^DATA_WIDTH-1; any saturating lane sets ovf.
  - op=2: new = max(base, vector_in) lane-wise.
  - eof_in=0: acc[c]<=new; in_frame[c]<=1; ovf[c]<=(start?0:ovf[c]) | sat; valid_out=0.
  - eof_in=1: vector_out<=new; valid_out=1; eof_out=1; bof_out=1; chainId_out=c; overflow_out=combined ovf; in_frame[c]<=0; ovf[c]<=0.
  - bof_in & eof_in in the same cycle: single-vector frame; output = vector_in under sum or max.
  - bof_in while already in ACCUM: the partial frame is dropped and a new one started; no output.
  - Any other op value behaves as op=0.
- valid_in=0: valid_out=0; other outputs hold their last values; state unchanged.
- tracing=0 (configuration mode):
  - valid_out=0; acc and in_frame untouched.
  - configId==PERSONAL_CONFIG_ID: byte_counter increments each cycle; byte k<MAX_CHAINS writes firmware_op[k]; later bytes are ignored; byte_counter saturates at 255.
  - configId!=PERSONAL_CONFIG_ID: byte_counter<=0.
- Width rules: adds are DATA_WIDTH+1 wide internally, then clamped. Comparisons are unsigned.

Decomposition:
- Shared package (lebug_pkg): ACC_OP_PASS=8'd0, ACC_OP_SUM=8'd1, ACC_OP_MAX=8'd2; typedef vector_t (N x DATA_WIDTH); config byte-counter width.
- One sub-module, acc_lane_alu: combinational op, base, in -> result plus sat flag for one lane; instantiated N times.

Test Plan:
- Reset, all ops=1; chain 0 sends bof=[1..8], mid=[1..8], eof=[2..9] -> one output cycle later: [4,7,10,...,25], eof_out=1, chainId_out=0; no valid_out on the first two vectors.
- Op=2 on chain 1, interleaved with op=1 on chain 0: chain1 frame [5],[9],[3](eof) on lane0 -> 9; chain 0 result unaffected by the interleaving.
- Op=1 sum: lane0 0xFFFFFFF0 + 0x20 -> 0xFFFFFFFF, overflow_out=1; the next frame on the same chain -> overflow_out=0.
- Config: tracing=0, configId=2, bytes 0,2,1,0 -> ops=[pass,max,sum,pass]; chain 0 vector [7..] is echoed with valid_out 1 cycle later, and valid_out=0 throughout config.
- Single-vector frame (bof&eof) with op=1 -> output equals the input; a non-bof vector on an idle chain starts a fresh frame (base 0).
- reset_n pulsed low mid-frame -> outputs 0 immediately; the following eof-only vector [1..8] outputs [1..8].
